// File: rtl/aes_spi_pkg.sv
// Shared types and sizing helpers for the SPI frame master feeding the AES receivers.
// Holds the control FSM state encoding and the bit-counter width.
package aes_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH,
        GAP
    } spi_state_t;

    localparam int unsigned DEFAULT_DATASIZE = 128;
    localparam int unsigned BIT_CNT_W        = $clog2(DEFAULT_DATASIZE);

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, serial-in shift register; the MSB is the serial output.
// Load has priority over shift.
module spi_shift_reg #(
    parameter int DATASIZE = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic                serial_in,
    input  logic [DATASIZE-1:0] load_data,
    output logic [DATASIZE-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= (q << 1) | DATASIZE'(serial_in);
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// SPI master: shifts one DATASIZE-bit word out on mosi (MSB first) under an active-low cs,
// one bit per clk, while capturing miso into data_out.
module spi_frame_master
    import aes_spi_pkg::*;
#(
    parameter int DATASIZE   = 128,
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATASIZE-1:0] data_in,
    output logic                busy,
    output logic                done,
    output logic [DATASIZE-1:0] data_out,
    output logic                cs,
    output logic                mosi,
    input  logic                miso
);

    localparam int CNT_W = cnt_width(DATASIZE);
    localparam int GAP_W = cnt_width(GAP_CYCLES);

    spi_state_t state, next_state;

    logic [CNT_W-1:0]    bit_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic                load;
    logic                shift;
    logic [DATASIZE-1:0] tx_q;
    logic [DATASIZE-2:0] rx_q;

    spi_shift_reg #(.DATASIZE(DATASIZE)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .serial_in (1'b0),
        .load_data (data_in),
        .q         (tx_q)
    );

    // The final miso bit goes straight into data_out, so the receive register is one bit short.
    spi_shift_reg #(.DATASIZE(DATASIZE-1)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .serial_in (miso),
        .load_data ('0),
        .q         (rx_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FINISH and the IDLE cycle both hold cs high, so GAP only supplies the remaining GAP_CYCLES-2.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        cs         = 1'b1;
        mosi       = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = SHIFT;
                    load       = 1'b1;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                cs    = 1'b0;
                mosi  = tx_q[DATASIZE-1];
                if (bit_cnt == '0) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                next_state = (GAP_CYCLES > 2) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (load) begin
            bit_cnt <= CNT_W'(DATASIZE - 1);
        end else if (shift) begin
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt <= '0;
        end else if (state == FINISH) begin
            gap_cnt <= GAP_W'((GAP_CYCLES > 2) ? GAP_CYCLES - 3 : 0);
        end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
        end else if (shift && bit_cnt == '0) begin
            data_out <= {rx_q, miso};
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: table-driven single frames on a 128-bit instance,
// plus reset-abort and back-to-back sequences (the latter on an 8-bit instance).
module tb_spi_frame_master;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] data_in;
    logic         busy, done, cs, mosi, miso;
    logic [127:0] data_out;
    int           mode;

    logic         start8;
    logic [7:0]   data8;
    logic         busy8, done8, cs8, mosi8;
    logic [7:0]   data_out8;

    int checks;
    int errors;

    typedef struct {
        logic [127:0] data;
        int           mode;   // 0: loopback, 1: miso=1, 2: miso=0
        int           glitch; // bit index at which a stray start is pulsed, -1 for none
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[5];

    spi_frame_master #(.DATASIZE(128), .GAP_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso)
    );

    spi_frame_master #(.DATASIZE(8), .GAP_CYCLES(2)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .data_in  (data8),
        .busy     (busy8),
        .done     (done8),
        .data_out (data_out8),
        .cs       (cs8),
        .mosi     (mosi8),
        .miso     (mosi8)
    );

    always_comb miso = (mode == 0) ? mosi : (mode == 1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int           cycles;
        int           mosi_err;
        int           done_cnt;
        int           n;
        logic [127:0] d;
        d       = v.data;
        mode    = v.mode;
        start   = 1'b1;
        data_in = d;
        tick();
        start    = 1'b0;
        data_in  = ~d;
        cycles   = 0;
        mosi_err = 0;
        done_cnt = 0;
        while (cs == 1'b0 && cycles < 300) begin
            if (cycles >= 128 || mosi !== d[127-cycles]) mosi_err++;
            if (done) done_cnt++;
            if (cycles == v.glitch) begin
                start   = 1'b1;
                data_in = d ^ 128'h5a5a;
            end
            tick();
            if (cycles == v.glitch) start = 1'b0;
            cycles++;
        end
        chk("cs_low_len", 128'(cycles), 128'd128);
        chk("mosi_seq_err", 128'(mosi_err), 128'd0);
        chk("done_latency", 128'(done), 128'd1);
        chk("data_out", data_out, v.exp);
        chk("mosi_cs_high", 128'(mosi), 128'd0);
        if (done) done_cnt++;
        n = 0;
        while (busy && n < 20) begin
            tick();
            if (done) done_cnt++;
            n++;
        end
        chk("busy_fall", 128'(busy), 128'd0);
        chk("done_count", 128'(done_cnt), 128'd1);
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] c3;
        logic       exp_cs;
        logic       exp_mosi;
        logic       exp_done;
        int         n;

        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        start   = 1'b0;
        data_in = '0;
        mode    = 0;
        start8  = 1'b0;
        data8   = '0;
        a5      = 8'ha5;
        c3      = 8'h3c;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 0, -1, 128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{128'h80000000000000000000000000000001, 0, -1, 128'h80000000000000000000000000000001};
        vecs[2] = '{128'h0, 1, -1, {128{1'b1}}};
        vecs[3] = '{{128{1'b1}}, 2, -1, 128'h0};
        vecs[4] = '{128'h0123456789abcdeffedcba9876543210, 0, 50, 128'h0123456789abcdeffedcba9876543210};

        #3;
        chk("rst_cs", 128'(cs), 128'd1);
        chk("rst_mosi", 128'(mosi), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_data_out", data_out, 128'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i]);
            tick();
        end

        // Reset in the middle of a frame
        mode    = 0;
        start   = 1'b1;
        data_in = 128'hfedcba98765432100123456789abcdef;
        tick();
        start = 1'b0;
        repeat (64) tick();
        chk("mid_cs_low", 128'(cs), 128'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_cs", 128'(cs), 128'd1);
        chk("abort_mosi", 128'(mosi), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        chk("abort_data_out", data_out, 128'd0);
        tick();
        chk("abort_hold_cs", 128'(cs), 128'd1);
        #2;
        rst = 1'b1;
        tick();
        run_frame(vecs[0]);

        // Back-to-back frames on the 8-bit instance with start held high
        start8 = 1'b1;
        data8  = a5;
        tick();
        data8 = c3;
        for (int cyc = 0; cyc < 20; cyc++) begin
            exp_done = (cyc == 8 || cyc == 18);
            if (cyc < 8) begin
                exp_cs   = 1'b0;
                exp_mosi = a5[7-cyc];
            end else if (cyc >= 10 && cyc < 18) begin
                exp_cs   = 1'b0;
                exp_mosi = c3[17-cyc];
            end else begin
                exp_cs   = 1'b1;
                exp_mosi = 1'b0;
            end
            chk($sformatf("b2b_cyc%0d_cs_mosi_done", cyc),
                128'({cs8, mosi8, done8}), 128'({exp_cs, exp_mosi, exp_done}));
            if (cyc == 8)  chk("b2b_data_out_a5", 128'(data_out8), 128'h a5);
            if (cyc == 18) begin
                chk("b2b_data_out_3c", 128'(data_out8), 128'h3c);
                start8 = 1'b0;
            end
            tick();
        end
        n = 0;
        while (busy8 && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_idle", 128'({busy8, cs8}), 128'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
